// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related muxes:
// FSM encoding, synchroniser depth and the round-robin pick function.
package uart_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_RISE,
        WAIT_FALL
    } arb_state_e;

    // First set bit of valid at or after ptr, wrapping within n sources; one-hot result.
    function automatic logic [7:0] next_rr(input logic [2:0] ptr,
                                           input logic [7:0] valid,
                                           input int         n);
        logic [7:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (!found && valid[idx[2:0]]) begin
                    pick[idx[2:0]] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker with wrap-around; reusable by any
// byte-stream mux that shares one sink between up to eight sources.
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [PTR_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] pick
);

    always_comb begin
        pick = NUM_REQ'(next_rr(3'(ptr), 8'(valid), NUM_REQ));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources with round-robin
// grants, packet lock, start/busy handshaking and a start-acknowledge timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ACK_TIMEOUT = 4096,
    parameter int TO_W        = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 ack_err,
    input  logic                 err_clr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e            state, state_next;
    logic [SYNC_DEPTH-1:0] busy_sync;
    logic                  busy_s;
    logic [PTR_W-1:0]      ptr, g_idx, ptr_after;
    logic                  lock;
    logic [TO_W-1:0]       to_cnt;
    logic [NUM_REQ-1:0]    pick;
    logic [7:0]            data_mux;
    logic                  owner_valid, owner_last, timeout;

    rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_picker (
        .ptr   (ptr),
        .valid (req_valid),
        .pick  (pick)
    );

    assign busy_s      = busy_sync[SYNC_DEPTH-1];
    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);
    assign timeout     = (state == WAIT_RISE) && !busy_s &&
                         (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign ptr_after   = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        g_idx    = '0;
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx    = PTR_W'(i);
                data_mux = req_data[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (lock ? owner_valid : |req_valid) state_next = LOAD;
            LOAD:      state_next = owner_valid ? START : IDLE;
            START:     state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (busy_s)       state_next = WAIT_FALL;
                else if (timeout) state_next = IDLE;
            end
            WAIT_FALL: if (!busy_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // tx_start is held for all of WAIT_RISE so a slow baud-tick transmitter cannot miss it.
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        case (state)
            START:     req_ready = grant;
            WAIT_RISE: tx_start  = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_sync <= '0;
            grant     <= '0;
            ptr       <= '0;
            lock      <= 1'b0;
            tx_data   <= '0;
            to_cnt    <= '0;
            ack_err   <= 1'b0;
        end else begin
            busy_sync <= {busy_sync[SYNC_DEPTH-2:0], tx_busy};
            if (err_clr) ack_err <= 1'b0;
            if (timeout) ack_err <= 1'b1;
            case (state)
                IDLE: if (!lock && |req_valid) grant <= pick;
                LOAD: begin
                    if (owner_valid) begin
                        tx_data <= data_mux;
                        lock    <= !owner_last;
                    end else if (!lock) begin
                        grant <= '0;
                    end
                end
                START: to_cnt <= '0;
                WAIT_RISE: begin
                    to_cnt <= to_cnt + 1'b1;
                    // Unacknowledged byte is dropped and the line handed on.
                    if (timeout) begin
                        lock  <= 1'b0;
                        grant <= '0;
                        ptr   <= ptr_after;
                    end
                end
                WAIT_FALL: begin
                    if (!busy_s && !lock) begin
                        grant <= '0;
                        ptr   <= ptr_after;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued sources, a behavioural
// transmitter, and per-scenario tasks checking grants, latency and timeout.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int ACK_TIMEOUT = 16;
    localparam int TO_W        = 5;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]   req_last  = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy   = 1'b0;
    logic [NUM_REQ-1:0]   grant;
    logic                 ack_err;
    logic                 err_clr   = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] src_q [NUM_REQ][$];   // {last, data}
    logic [7:0] exp_q [$];
    bit         tx_model_en = 1'b1;
    int         busy_cnt    = 0;
    logic       start_prev  = 1'b0;
    logic [8:0] head;
    logic [7:0] exp_byte;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .ack_err   (ack_err),
        .err_clr   (err_clr)
    );

    // Sources: present queue head, pop when the arbiter accepts it.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i] && src_q[i].size() > 0) src_q[i].delete(0);
            if (src_q[i].size() > 0) begin
                head               = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = head[7:0];
                req_last[i]        = head[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Transmitter: raise busy for six cycles after seeing a start.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            tx_busy  = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end else if (tx_model_en && tx_start) begin
            tx_busy  = 1'b1;
            busy_cnt = 6;
        end
    end

    // Scoreboard: each start edge must carry the next expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_start && !start_prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: tx_data=%02h, expected no byte", tx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (tx_data !== exp_byte) begin
                    n_bad++;
                    $display("FAIL sb_data: tx_data=%02h expected=%02h", tx_data, exp_byte);
                end
            end
        end
        start_prev = tx_start;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_queues();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(srcs_empty() && exp_q.size() == 0 && grant == '0 && !tx_busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle: not idle after %0d cycles, grant=%b pending=%0d", name, n, grant, exp_q.size());
        end
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (grant == '0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_grant_wait: no grant within 50 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({req_ready, tx_start, tx_data, grant, ack_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%b start=%b data=%02h grant=%b err=%b, expected all 0",
                     req_ready, tx_start, tx_data, grant, ack_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        int n;
        bit bad_grant = 1'b0;
        src_q[0].push_back({1'b1, 8'h55});
        exp_q.push_back(8'h55);
        n = 0;
        while (!req_valid[0] && n < 10) begin tick(); n++; end
        n = 0;
        while (!req_ready[0] && n < 10) begin tick(); n++; end
        n_cmp++;
        if (n != 2) begin
            n_bad++;
            $display("FAIL single_ready_latency: %0d cycles, expected 2", n);
        end
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_bad++;
            $display("FAIL single_ready_onehot: req_ready=%b expected=001", req_ready);
        end
        n_cmp++;
        if (tx_data !== 8'h55) begin
            n_bad++;
            $display("FAIL single_tx_data: tx_data=%02h expected=55", tx_data);
        end
        tick();
        n_cmp++;
        if (tx_start !== 1'b1 || req_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL single_start_latency: tx_start=%b req_ready=%b expected 1/000", tx_start, req_ready);
        end
        n = 0;
        while (tx_start && n < 50) begin
            if (grant !== 3'b001) bad_grant = 1'b1;
            tick();
            n++;
        end
        n_cmp++;
        if (bad_grant || n >= 50 || n < 3) begin
            n_bad++;
            $display("FAIL single_start_hold: start held %0d cycles, grant_ok=%b", n, !bad_grant);
        end
        n = 0;
        while (grant != '0 && n < 50) begin tick(); n++; end
        n_cmp++;
        if (tx_busy !== 1'b0 || grant !== 3'b000) begin
            n_bad++;
            $display("FAIL single_release: grant=%b tx_busy=%b, expected grant 000 after busy falls", grant, tx_busy);
        end
        wait_idle("single", 100);
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] prev = '0;
        int seen = 0;
        int n    = 0;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                src_q[i].push_back({1'b1, 8'hA0 + 8'(i)});
                exp_q.push_back(8'hA0 + 8'(i));
            end
        end
        while (seen < 6 && n < 400) begin
            tick();
            n++;
            if (req_ready != '0) begin
                if (seen > 0) begin
                    n_cmp++;
                    if (req_ready === prev) begin
                        n_bad++;
                        $display("FAIL rr_repeat: source %b served twice in a row", req_ready);
                    end
                end
                prev = req_ready;
                seen++;
            end
        end
        wait_idle("rr", 400);
    endtask

    task automatic test_packet_lock();
        int n = 0;
        bit bad_grant = 1'b0;
        for (int b = 0; b < 4; b++) begin
            src_q[1].push_back({b == 3, 8'h10 + 8'(b)});
            exp_q.push_back(8'h10 + 8'(b));
        end
        wait_grant("lock");
        n_cmp++;
        if (grant !== 3'b010) begin
            n_bad++;
            $display("FAIL lock_first_grant: grant=%b expected=010", grant);
        end
        src_q[0].push_back({1'b1, 8'h20});
        src_q[2].push_back({1'b1, 8'h22});
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h20);
        while (exp_q.size() > 2 && n < 400) begin
            if (grant !== 3'b010) bad_grant = 1'b1;
            tick();
            n++;
        end
        n_cmp++;
        if (bad_grant || n >= 400) begin
            n_bad++;
            $display("FAIL lock_hold: grant left 010 during packet (cycles=%0d)", n);
        end
        n = 0;
        while ((grant == 3'b010 || grant == 3'b000) && n < 100) begin tick(); n++; end
        n_cmp++;
        if (grant !== 3'b100) begin
            n_bad++;
            $display("FAIL lock_next_grant: grant=%b expected=100", grant);
        end
        wait_idle("lock", 400);
    endtask

    task automatic test_wrap_around();
        src_q[1].push_back({1'b1, 8'h41});
        exp_q.push_back(8'h41);
        wait_idle("wrap_setup", 100);
        src_q[0].push_back({1'b1, 8'h40});
        src_q[1].push_back({1'b1, 8'h42});
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h42);
        wait_grant("wrap");
        n_cmp++;
        if (grant !== 3'b001) begin
            n_bad++;
            $display("FAIL wrap_grant: grant=%b expected=001", grant);
        end
        wait_idle("wrap", 200);
    endtask

    task automatic test_timeout();
        int n = 0;
        tx_model_en = 1'b0;
        src_q[2].push_back({1'b1, 8'h77});
        src_q[0].push_back({1'b1, 8'h70});
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h70);
        while (!tx_start && n < 50) begin tick(); n++; end
        n = 0;
        while (!ack_err && n < 40) begin tick(); n++; end
        n_cmp++;
        if (n != ACK_TIMEOUT) begin
            n_bad++;
            $display("FAIL timeout_delay: ack_err after %0d cycles, expected %0d", n, ACK_TIMEOUT);
        end
        n_cmp++;
        if (tx_start !== 1'b0 || grant !== 3'b000) begin
            n_bad++;
            $display("FAIL timeout_release: tx_start=%b grant=%b expected 0/000", tx_start, grant);
        end
        tx_model_en = 1'b1;
        wait_grant("timeout");
        n_cmp++;
        if (grant !== 3'b001) begin
            n_bad++;
            $display("FAIL timeout_next_grant: grant=%b expected=001", grant);
        end
        repeat (3) tick();
        n_cmp++;
        if (ack_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_sticky: ack_err=%b expected=1", ack_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (ack_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear: ack_err=%b expected=0", ack_err);
        end
        wait_idle("timeout", 200);
    endtask

    task automatic test_async_reset();
        int n = 0;
        src_q[2].push_back({1'b1, 8'hC2});
        exp_q.push_back(8'hC2);
        while (!tx_start && n < 50) begin tick(); n++; end
        n = 0;
        while (tx_start && n < 50) begin tick(); n++; end
        n_cmp++;
        if (grant !== 3'b100 || tx_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_setup: grant=%b tx_busy=%b expected 100/1", grant, tx_busy);
        end
        #2;
        rst_n = 1'b0;
        clear_queues();
        #1;
        n_cmp++;
        if ({req_ready, tx_start, tx_data, grant, ack_err} !== '0) begin
            n_bad++;
            $display("FAIL areset_outputs: ready=%b start=%b data=%02h grant=%b err=%b, expected all 0",
                     req_ready, tx_start, tx_data, grant, ack_err);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        src_q[0].push_back({1'b1, 8'hD0});
        src_q[2].push_back({1'b1, 8'hD2});
        exp_q.push_back(8'hD0);
        exp_q.push_back(8'hD2);
        wait_grant("areset");
        n_cmp++;
        if (grant !== 3'b001) begin
            n_bad++;
            $display("FAIL areset_first_grant: grant=%b expected=001", grant);
        end
        wait_idle("areset", 200);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_wrap_around();
        test_timeout();
        test_async_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d expected bytes never sent", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
